// File: rtl/sample_ntt_rejection_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sample_ntt_rejection_pkg
// Purpose  : Shared ML-KEM keygen constants and the NTT sampler state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package sample_ntt_rejection_pkg;

    localparam int KG_Q         = 3329;
    localparam int KG_N         = 256;
    localparam int KG_COEF_W    = 12;
    localparam int KG_RATE      = 1344;
    localparam int KG_BLK_BYTES = KG_RATE / 8;
    localparam int KG_TRIPLES   = KG_BLK_BYTES / 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BLK = 2'd1,
        PARSE_D1 = 2'd2,
        PARSE_D2 = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sample_ntt_rejection_triple_parse.sv
`default_nettype none
// ============================================================================
// Module   : triple_parse
// Purpose  : Splits one 3-byte group into two 12-bit candidates and flags
//            which of them fall below the modulus.
// Revision : 1.0 - initial release
// ============================================================================
module triple_parse
    import sample_ntt_rejection_pkg::*;
#(
    parameter int Q      = KG_Q,
    parameter int COEF_W = KG_COEF_W
) (
    input  logic [2*COEF_W-1:0] i_triple,
    output logic [COEF_W-1:0]   o_d1,
    output logic [COEF_W-1:0]   o_d2,
    output logic                o_ok1,
    output logic                o_ok2
);

    // With bytes packed little-endian, {b1[3:0],b0} and {b2,b1[7:4]} are
    // simply the low and high halves of the 24-bit group.
    assign o_d1  = i_triple[COEF_W-1:0];
    assign o_d2  = i_triple[2*COEF_W-1:COEF_W];
    assign o_ok1 = (o_d1 < COEF_W'(Q));
    assign o_ok2 = (o_d2 < COEF_W'(Q));

endmodule
`default_nettype wire

// File: rtl/sample_ntt_rejection.sv
`default_nettype none
// ============================================================================
// Module   : sample_ntt_rejection
// Purpose  : Pulls SHAKE128 rate blocks and rejection-samples 12-bit
//            candidates against q, streaming N accepted coefficients.
// Revision : 1.0 - initial release
// ============================================================================
module sample_ntt_rejection
    import sample_ntt_rejection_pkg::*;
#(
    parameter int Q      = KG_Q,
    parameter int N      = KG_N,
    parameter int RATE   = KG_RATE,
    parameter int COEF_W = KG_COEF_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    output logic              o_busy,
    input  logic              i_xof_valid,
    input  logic [RATE-1:0]   i_xof_data,
    output logic              o_xof_req,
    output logic              o_coef_valid,
    input  logic              i_coef_ready,
    output logic [COEF_W-1:0] o_coef,
    output logic [7:0]        o_coef_idx,
    output logic              o_done
);

    localparam int TRIPLE_W = 2 * COEF_W;
    localparam int TRIPLES  = RATE / TRIPLE_W;
    localparam int J_W      = $clog2(TRIPLES);

    localparam logic [J_W-1:0] c_last_j   = J_W'(TRIPLES - 1);
    localparam logic [8:0]     c_last_cnt = 9'(N - 1);

    state_t              r_state;
    logic [RATE-1:0]     r_buf;
    logic [J_W-1:0]      r_j;
    logic [8:0]          r_cnt;

    logic [TRIPLE_W-1:0] w_triples [TRIPLES];
    logic [TRIPLE_W-1:0] w_triple;
    logic [COEF_W-1:0]   w_d1;
    logic [COEF_W-1:0]   w_d2;
    logic                w_ok1;
    logic                w_ok2;
    logic                w_last;

    for (genvar g = 0; g < TRIPLES; g++) begin : g_triple
        assign w_triples[g] = r_buf[TRIPLE_W*g +: TRIPLE_W];
    end

    assign w_triple = w_triples[r_j];
    assign w_last   = (r_cnt == c_last_cnt);

    triple_parse #(
        .Q      (Q),
        .COEF_W (COEF_W)
    ) u_triple_parse (
        .i_triple (w_triple),
        .o_d1     (w_d1),
        .o_d2     (w_d2),
        .o_ok1    (w_ok1),
        .o_ok2    (w_ok2)
    );

    // Stream outputs decode purely from registered state, so they stay
    // stable through a ready stall and have no input-to-output path.
    assign o_coef_valid = ((r_state == PARSE_D1) && w_ok1) ||
                          ((r_state == PARSE_D2) && w_ok2);
    assign o_coef       = (r_state == PARSE_D2) ? w_d2 : w_d1;
    assign o_coef_idx   = r_cnt[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_buf     <= '0;
            r_j       <= '0;
            r_cnt     <= '0;
            o_xof_req <= 1'b0;
            o_done    <= 1'b0;
            o_busy    <= 1'b0;
        end else begin
            o_xof_req <= 1'b0;
            o_done    <= 1'b0;
            if (o_done) begin
                o_busy <= 1'b0;
            end
            if (i_start) begin
                r_state <= WAIT_BLK;
                r_j     <= '0;
                r_cnt   <= '0;
                o_busy  <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= IDLE;
                    end
                    WAIT_BLK: begin
                        if (i_xof_valid) begin
                            r_buf     <= i_xof_data;
                            r_j       <= '0;
                            o_xof_req <= 1'b1;
                            r_state   <= PARSE_D1;
                        end
                    end
                    PARSE_D1: begin
                        if (!w_ok1) begin
                            r_state <= PARSE_D2;
                        end else if (i_coef_ready) begin
                            r_cnt <= r_cnt + 9'd1;
                            if (w_last) begin
                                o_done  <= 1'b1;
                                r_state <= IDLE;
                            end else begin
                                r_state <= PARSE_D2;
                            end
                        end
                    end
                    PARSE_D2: begin
                        if (w_ok2 && i_coef_ready && w_last) begin
                            r_cnt   <= r_cnt + 9'd1;
                            o_done  <= 1'b1;
                            r_state <= IDLE;
                        end else if (!w_ok2 || i_coef_ready) begin
                            if (w_ok2) begin
                                r_cnt <= r_cnt + 9'd1;
                            end
                            if (r_j == c_last_j) begin
                                r_state <= WAIT_BLK;
                            end else begin
                                r_j     <= r_j + 1'b1;
                                r_state <= PARSE_D1;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sample_ntt_rejection.sv
`default_nettype none
// ============================================================================
// Module   : tb_sample_ntt_rejection
// Purpose  : Directed self-checking bench for the NTT rejection sampler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sample_ntt_rejection;
    import sample_ntt_rejection_pkg::*;

    localparam int RATE = KG_RATE;

    logic            clk;
    logic            rst_n;
    logic            i_start;
    logic            o_busy;
    logic            i_xof_valid;
    logic [RATE-1:0] i_xof_data;
    logic            o_xof_req;
    logic            o_coef_valid;
    logic            i_coef_ready;
    logic [11:0]     o_coef;
    logic [7:0]      o_coef_idx;
    logic            o_done;

    sample_ntt_rejection dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .o_busy       (o_busy),
        .i_xof_valid  (i_xof_valid),
        .i_xof_data   (i_xof_data),
        .o_xof_req    (o_xof_req),
        .o_coef_valid (o_coef_valid),
        .i_coef_ready (i_coef_ready),
        .o_coef       (o_coef),
        .o_coef_idx   (o_coef_idx),
        .o_done       (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int rcv_val[$];
    int rcv_idx[$];
    int rcv_cyc[$];
    int req_cycs[$];
    logic [RATE-1:0] blocks[$];
    logic pending = 1'b0;
    int   dly     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [RATE-1:0] fill_blk(input logic [23:0] t);
        logic [RATE-1:0] b;
        for (int k = 0; k < KG_TRIPLES; k++) b[24*k +: 24] = t;
        return b;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // XOF stand-in: valid drops on start/req and the next queued block
    // appears a few cycles later.
    always @(posedge clk) begin
        #2;
        if (!rst_n) begin
            i_xof_valid = 1'b0;
            pending     = 1'b0;
        end else if (i_start || o_xof_req) begin
            i_xof_valid = 1'b0;
            pending     = 1'b1;
            dly         = 3;
        end else if (pending) begin
            if (dly > 0) begin
                dly = dly - 1;
            end else if (blocks.size() > 0) begin
                i_xof_data  = blocks.pop_front();
                i_xof_valid = 1'b1;
                pending     = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_coef_valid && i_coef_ready) begin
                rcv_val.push_back(int'(o_coef));
                rcv_idx.push_back(int'(o_coef_idx));
                rcv_cyc.push_back(cyc);
            end
            if (o_xof_req) req_cycs.push_back(cyc);
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_logs();
        rcv_val.delete();
        rcv_idx.delete();
        rcv_cyc.delete();
        req_cycs.delete();
        blocks.delete();
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int errs;
        int gap;
        logic [RATE-1:0] blk;
        logic [11:0] c0;
        logic [7:0]  i0;

        rst_n        = 1'b0;
        i_start      = 1'b0;
        i_coef_ready = 1'b0;
        i_xof_valid  = 1'b0;
        i_xof_data   = '0;
        tick(3);
        check("rst_busy",  32'(o_busy), 0);
        check("rst_req",   32'(o_xof_req), 0);
        check("rst_valid", 32'(o_coef_valid), 0);
        check("rst_coef",  32'(o_coef), 0);
        check("rst_idx",   32'(o_coef_idx), 0);
        check("rst_done",  32'(o_done), 0);
        rst_n = 1'b1;
        tick(2);

        // All-zero blocks: full 256-coefficient run.
        clear_logs();
        i_coef_ready = 1'b1;
        pulse_start();
        check("t1_busy_after_start", 32'(o_busy), 1);
        for (int k = 0; k < 4; k++) blocks.push_back('0);
        for (int k = 0; k < 2000; k++) begin
            if (o_done) break;
            @(posedge clk); #1;
        end
        check("t1_done_seen", 32'(o_done), 1);
        check("t1_busy_at_done", 32'(o_busy), 1);
        tick(1);
        check("t1_busy_after_done", 32'(o_busy), 0);
        check("t1_count", 32'(rcv_val.size()), 256);
        errs = 0;
        for (int k = 0; k < rcv_val.size(); k++)
            if (rcv_val[k] != 0 || rcv_idx[k] != (k % 256)) errs++;
        check("t1_seq_err", 32'(errs), 0);
        check("t1_req_pulses", 32'(req_cycs.size()), 3);
        check("t1_done_cnt", 32'(done_cnt), 1);
        gap = (rcv_cyc.size() > 0) ? done_cyc - rcv_cyc[$] : -1;
        check("t1_done_gap", 32'(gap), 1);

        // Boundary candidates 3328 / 3329 and an all-ones triple.
        clear_logs();
        pulse_start();
        blk = fill_blk(24'hFFFFFF);
        blk[0 +: 24]  = 24'hD01D00;
        blk[48 +: 24] = 24'h032001;
        blocks.push_back(blk);
        tick(150);
        check("t2_count", 32'(rcv_val.size()), 3);
        check("t2_val0", 32'((rcv_val.size() > 0) ? rcv_val[0] : -1), 3328);
        check("t2_idx0", 32'((rcv_idx.size() > 0) ? rcv_idx[0] : -1), 0);
        check("t2_val1", 32'((rcv_val.size() > 1) ? rcv_val[1] : -1), 1);
        check("t2_idx1", 32'((rcv_idx.size() > 1) ? rcv_idx[1] : -1), 1);
        check("t2_val2", 32'((rcv_val.size() > 2) ? rcv_val[2] : -1), 50);
        check("t2_idx2", 32'((rcv_idx.size() > 2) ? rcv_idx[2] : -1), 2);
        check("t2_req_pulses", 32'(req_cycs.size()), 1);

        // Long rejected stretch: 50 all-ones triples, then 5/6 pairs.
        clear_logs();
        pulse_start();
        blk = fill_blk(24'h006005);
        for (int k = 0; k < 50; k++) blk[24*k +: 24] = 24'hFFFFFF;
        blocks.push_back(blk);
        tick(200);
        gap = (rcv_cyc.size() > 0 && req_cycs.size() > 0) ? rcv_cyc[0] - req_cycs[0] : -1;
        check("t3_first_gap", 32'(gap), 100);
        check("t3_count", 32'(rcv_val.size()), 12);
        errs = 0;
        for (int k = 0; k < rcv_val.size(); k++)
            if (rcv_val[k] != ((k % 2 == 0) ? 5 : 6) || rcv_idx[k] != k) errs++;
        check("t3_seq_err", 32'(errs), 0);
        check("t3_req_pulses", 32'(req_cycs.size()), 1);

        // Ready stall: output must hold for 10 cycles.
        clear_logs();
        i_coef_ready = 1'b0;
        pulse_start();
        blocks.push_back(fill_blk(24'h006005));
        for (int k = 0; k < 50; k++) begin
            if (o_coef_valid) break;
            @(posedge clk); #1;
        end
        c0 = o_coef;
        i0 = o_coef_idx;
        check("t4_valid", 32'(o_coef_valid), 1);
        check("t4_coef", 32'(c0), 5);
        check("t4_idx", 32'(i0), 0);
        errs = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (!o_coef_valid || o_coef != c0 || o_coef_idx != i0) errs++;
        end
        check("t4_stable_err", 32'(errs), 0);
        i_coef_ready = 1'b1;
        tick(1);
        i_coef_ready = 1'b0;
        check("t4_xfer_count", 32'(rcv_val.size()), 1);
        check("t4_next_valid", 32'(o_coef_valid), 1);
        check("t4_next_coef", 32'(o_coef), 6);
        check("t4_next_idx", 32'(o_coef_idx), 1);

        // Abort at cnt=40, then fresh run on the next block.
        i_coef_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (o_coef_valid && o_coef_idx == 8'd40) break;
            @(posedge clk); #1;
        end
        check("t5_reach_idx40", 32'(o_coef_idx), 40);
        i_coef_ready = 1'b0;
        pulse_start();
        check("t5_xfers_before_abort", 32'(rcv_val.size()), 40);
        check("t5_valid_dropped", 32'(o_coef_valid), 0);
        check("t5_busy", 32'(o_busy), 1);
        blocks.delete();
        blocks.push_back(fill_blk(24'h00A009));
        i_coef_ready = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (rcv_val.size() >= 42) break;
            @(posedge clk); #1;
        end
        check("t5_new_idx0", 32'((rcv_idx.size() > 40) ? rcv_idx[40] : -1), 0);
        check("t5_new_val0", 32'((rcv_val.size() > 40) ? rcv_val[40] : -1), 9);
        check("t5_new_idx1", 32'((rcv_idx.size() > 41) ? rcv_idx[41] : -1), 1);
        check("t5_new_val1", 32'((rcv_val.size() > 41) ? rcv_val[41] : -1), 10);
        check("t5_no_done", 32'(done_cnt), 1);

        // Asynchronous reset while parsing.
        check("t6_pre_valid", 32'(o_coef_valid), 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(o_coef_valid), 0);
        check("t6_rst_coef",  32'(o_coef), 0);
        check("t6_rst_idx",   32'(o_coef_idx), 0);
        check("t6_rst_busy",  32'(o_busy), 0);
        tick(2);
        rst_n = 1'b1;
        errs = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (o_busy || o_coef_valid || o_xof_req || o_done) errs++;
        end
        check("t6_idle_activity", 32'(errs), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/sample_ntt_rejection.md
# sample_ntt_rejection

Consumer end of the SHAKE128 squeeze interface: it pulls 1344-bit rate blocks from the XOF, parses each 3-byte group into two 12-bit candidates, and rejection-samples them against q = 3329. It emits exactly N accepted coefficients, in order, on a valid/ready stream. It sits in the ML-KEM keygen datapath between the SHAKE128 instance and the matrix-A coefficient store.

## Interface
Parameters:
- Q, 3329, modulus; candidates d < Q are accepted.
- N, 256, number of coefficients emitted per start.
- RATE, 1344, XOF block width in bits (56 byte-triples per block).
- COEF_W, 12, coefficient width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  single-cycle pulse; begins a new polynomial. Asserted in the same cycle as the XOF's start.
- o_busy  out  1  high from the cycle after i_start until the cycle after o_done.
- i_xof_valid  in  1  XOF block available (connects to o_squeeze_valid).
- i_xof_data  in  RATE  XOF block; byte k = bits [8k+7:8k].
- o_xof_req  out  1  single-cycle pulse requesting the next block (connects to i_squeeze_req).
- o_coef_valid  out  1  accepted coefficient present.
- i_coef_ready  in  1  downstream accepts this cycle.
- o_coef  out  COEF_W  coefficient value.
- o_coef_idx  out  8  index 0..N-1 of o_coef.
- o_done  out  1  single-cycle pulse after the N-th coefficient is transferred.

## Operation
- States: IDLE, WAIT_BLK, PARSE_D1, PARSE_D2.
- Internal state: block buffer (RATE bits), triple index j (0..55), accepted count cnt (0..N).
- IDLE: on i_start, clear j and cnt, then go to WAIT_BLK.
- WAIT_BLK: when i_xof_valid is high, latch i_xof_data into the buffer, set j = 0, pulse o_xof_req for the next cycle only, and go to PARSE_D1. This prefetches the next block so the permutation overlaps parsing.
- i_xof_valid is sampled only in WAIT_BLK. Stale valid during the req cycle is ignored by construction.
- Candidate definitions, with b0, b1, b2 = buffer bytes 3j, 3j+1, 3j+2:
  - d1 = {b1[3:0], b0}.
  - d2 = {b2, b1[7:4]}.
- PARSE_D1: if d1 < Q, assert o_coef_valid with o_coef = d1 and o_coef_idx = cnt. Hold until i_coef_ready, then cnt++ and go to PARSE_D2. If d1 ≥ Q, go to PARSE_D2 in one cycle with no output.
- PARSE_D2: same handling for d2. On exit:
  - If j = 55, go to WAIT_BLK.
  - Otherwise j++ and go to PARSE_D1.
- Completion: when a transfer makes cnt = N, pulse o_done the next cycle and go to IDLE. The rest of the buffer is discarded. The outstanding prefetch is left unconsumed.
- Comparison is unsigned 12-bit. cnt is 9 bits so that N = 256 is representable; o_coef_idx = cnt[7:0].
- i_start in any state has priority: restart exactly as from IDLE. The same cycle also drops o_coef_valid, suppresses o_xof_req, and clears cnt and j. No o_done is produced for the aborted run.
- o_coef and o_coef_idx must stay stable while o_coef_valid is high and i_coef_ready is low.

## Timing
- Reset values: o_busy=0, o_xof_req=0, o_coef_valid=0, o_coef=0, o_coef_idx=0, o_done=0. State is IDLE, buffer is 0.
- i_start at cycle T: in WAIT_BLK at T+1; o_busy=1 from T+1.
- i_xof_valid sampled high in WAIT_BLK at cycle B: o_xof_req=1 in B+1 only; PARSE_D1 at B+1. The first coefficient can be valid at B+1.
- Throughput: 2 cycles per triple without stalls, i.e. 112 cycles per block, far longer than one Keccak-f.
- Rejected candidates cost 1 cycle each. Accepted candidates cost 1 cycle plus any ready stall.
- Last transfer at cycle L: o_done=1 at L+1, o_busy=0 at L+2.
- All outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs.

## Structure
- Shared keygen package holds:
  - Q, N, COEF_W.
  - RATE and the SHAKE128 block byte count (168).
  - The state enum.
- A small combinational sub-module, `triple_parse`, takes 24 bits and produces d1, d2 and their accept flags. The 56:1 triple mux selected by j lives in the top level.

## Test plan
- All-zero XOF blocks: 256 coefficients of value 0, idx 0..255. Exactly 3 o_xof_req pulses (112 + 112 + 32 coefficients). o_done occurs once, after transfer 255.
- Triple 00 1D D0 (d1=3328, d2=3329): 3328 is emitted and 3329 is rejected. Triple FF FF FF emits nothing. The following triple continues at the correct idx.
- Block whose first 50 triples are FF FF FF: no output for 100 cycles, then correct coefficients. No extra o_xof_req is issued during the rejected stretch.
- i_coef_ready held low for 10 cycles on a valid coefficient: o_coef and o_coef_idx remain stable, and cnt advances by exactly 1 after ready.
- i_start pulsed mid-block at cnt=40: o_coef_valid drops next cycle and no o_done is produced. A fresh run restarts at idx 0 using the next block presented.
- rst_n asserted mid-parse: all outputs return immediately to their reset values, and the block idles until i_start.
